// File: rtl/barret_1409_pkg.sv
// Shared constants and types for the q = 1409 Barrett reduction datapath.
package barret_1409_pkg;

   localparam int unsigned Q     = 1409;
   localparam int unsigned MU    = 2976;
   localparam int unsigned K     = 11;
   localparam int unsigned OP_W  = 21;
   localparam int unsigned RES_W = 11;

   typedef logic [RES_W-1:0] residue_t;
   typedef logic [OP_W-1:0]  operand_t;

endpackage

// File: rtl/barret_1409_rr_sched_if.sv
// Requester and response handshake bundle for the round-robin Barrett scheduler.
interface barret_1409_rr_sched_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
);
   import barret_1409_pkg::*;

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ*OP_W-1:0] req_data;
   logic [NUM_REQ-1:0]      req_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic [ID_W-1:0]         rsp_id;
   residue_t                rsp_data;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );

endinterface

// File: rtl/barret_1409_pipe.sv
// Two-stage Barrett reducer for q = 1409; both stages advance only when adv is high.
module barret_1409_pipe
   import barret_1409_pkg::*;
#(
   parameter int unsigned ID_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            adv,
   input  logic            in_valid,
   input  logic [ID_W-1:0] in_id,
   input  operand_t        in_data,
   output logic            s1_valid,
   output logic            out_valid,
   output logic [ID_W-1:0] out_id,
   output residue_t        out_data
);

   logic [OP_W-K-1:0] q_val;
   logic [21:0]       q_hat;
   residue_t          t_d;

   logic              s1_valid_q;
   logic [ID_W-1:0]   s1_id_q;
   operand_t          s1_a_q;
   residue_t          s1_t_q;

   operand_t          r0, r1, r2;

   logic              out_valid_q;
   logic [ID_W-1:0]   out_id_q;
   residue_t          out_data_q;

   always_comb begin
      q_val = in_data[OP_W-1:K];
      q_hat = 22'(q_val) * 22'(MU);
      t_d   = q_hat[21:K];
   end

   // t underestimates floor(a/q) by at most 2, hence two correction steps.
   always_comb begin
      r0 = s1_a_q - (OP_W'(s1_t_q) * OP_W'(Q));
      r1 = (r0 >= OP_W'(Q)) ? r0 - OP_W'(Q) : r0;
      r2 = (r1 >= OP_W'(Q)) ? r1 - OP_W'(Q) : r1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         s1_a_q      <= '0;
         s1_t_q      <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_data_q  <= '0;
      end else if (adv) begin
         s1_valid_q  <= in_valid;
         s1_id_q     <= in_id;
         s1_a_q      <= in_data;
         s1_t_q      <= t_d;
         out_valid_q <= s1_valid_q;
         out_id_q    <= s1_id_q;
         out_data_q  <= r2[RES_W-1:0];
      end
   end

   assign s1_valid  = s1_valid_q;
   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_data  = out_data_q;

endmodule

// File: rtl/barret_1409_rr_sched.sv
// Round-robin arbiter sharing one pipelined q = 1409 Barrett reducer among NUM_REQ requesters.
module barret_1409_rr_sched
   import barret_1409_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   barret_1409_rr_sched_if.slave   bus,
   output logic                    idle,
   output logic [15:0]             done_cnt
);

   logic               adv;
   logic               found;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    gnt_id;
   logic [NUM_REQ-1:0] grant;
   logic               in_valid;
   operand_t           in_data;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [15:0]        done_cnt_q;
   logic               s1_valid;
   logic               rsp_valid;
   logic [ID_W-1:0]    rsp_id;
   residue_t           rsp_data;

   assign adv = !rsp_valid || bus.rsp_ready;

   // First valid requester at or after the pointer, with wrap-around.
   always_comb begin
      found  = 1'b0;
      cand   = '0;
      gnt_id = '0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = ID_W'((32'(ptr_q) + off) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found  = 1'b1;
            gnt_id = cand;
         end
      end
   end

   always_comb begin
      grant    = '0;
      in_valid = found && adv && rst_n;
      if (in_valid) grant[gnt_id] = 1'b1;
   end

   always_comb begin
      in_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == ID_W'(i)) in_data = bus.req_data[i*OP_W +: OP_W];
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (in_valid) begin
         if (gnt_id == ID_W'(NUM_REQ - 1)) ptr_d = '0;
         else                              ptr_d = gnt_id + ID_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         done_cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (rsp_valid && bus.rsp_ready) done_cnt_q <= done_cnt_q + 16'd1;
      end
   end

   barret_1409_pipe #(
      .ID_W (ID_W)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_valid  (in_valid),
      .in_id     (gnt_id),
      .in_data   (in_data),
      .s1_valid  (s1_valid),
      .out_valid (rsp_valid),
      .out_id    (rsp_id),
      .out_data  (rsp_data)
   );

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_id    = rsp_id;
   assign bus.rsp_data  = rsp_data;
   assign idle          = !(s1_valid || rsp_valid);
   assign done_cnt      = done_cnt_q;

endmodule
